// File: rtl/pkt_frame_pkg.sv
// Shared frame definitions for the serial packet link (transmit and receive sides).
// Holds the frame geometry, the sync pattern and the transmit state encoding.
package pkt_frame_pkg;

    localparam int FRAME_W   = 64;
    localparam int SYNC_LSB  = 38;
    localparam int SYNC_W    = 8;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 8'hFF;
    localparam int PAYLOAD_W = FRAME_W - SYNC_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/pkt_frame_builder.sv
// Combinational payload -> frame mapping. The sync field is spliced in at
// SYNC_LSB; payload bits above it move up by SYNC_W, bits below stay in place.
// Ports:
//   i_payload  in   PAYLOAD_W  raw payload from the packet source
//   o_frame    out  FRAME_W    frame ready to be shifted out MSB-first
module pkt_frame_builder
    import pkt_frame_pkg::*;
(
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic [FRAME_W-1:0]   o_frame
);

    assign o_frame = {i_payload[PAYLOAD_W-1:SYNC_LSB], SYNC_PAT, i_payload[SYNC_LSB-1:0]};

endmodule

// File: rtl/pkt_serializer.sv
// Transmit-side packet serializer: accepts one payload per valid/ready handshake,
// frames it with the sync field and shifts it out MSB-first, one bit per en strobe,
// followed by GAP_BITS zero bits so the receiver can re-arm.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            bit strobe
//   abort         drop current frame/gap, line to 0, restart the gap
//   tx_valid      payload offered
//   tx_payload    payload (PAYLOAD_W bits)
//   tx_ready      high only in IDLE
//   dout          serial line (MSB of shift register while sending, else 0)
//   busy          high while sending or in the gap
//   frame_done    one-cycle pulse after the last bit of a frame is consumed
//   frame_cnt     completed frame count, wraps
//
// state | meaning
// IDLE  | line at 0, waiting for a payload
// SEND  | shifting frame out, one bit per en
// GAP   | line at 0 for GAP_BITS en strobes
module pkt_serializer
    import pkt_frame_pkg::*;
#(
    parameter int GAP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 abort,
    input  logic                 tx_valid,
    input  logic [PAYLOAD_W-1:0] tx_payload,
    output logic                 tx_ready,
    output logic                 dout,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           frame_cnt
);

    localparam int BIT_CW = $clog2(FRAME_W);
    // A zero-length gap still needs a 1-bit counter to keep widths legal.
    localparam int GAP_CW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(FRAME_W - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam tx_state_t ST_AFTER = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [FRAME_W-1:0]   r_sreg;
    logic [BIT_CW-1:0]    r_bit_cnt;
    logic [GAP_CW-1:0]    r_gap_cnt;
    logic                 r_frame_done;
    logic [7:0]           r_frame_cnt;
    logic [FRAME_W-1:0]   w_frame;
    logic                 w_last_bit;
    logic                 w_gap_last;

    pkt_frame_builder u_builder (
        .i_payload (tx_payload),
        .o_frame   (w_frame)
    );

    assign w_last_bit = (r_bit_cnt == BIT_LAST);
    assign w_gap_last = (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (tx_valid) w_state_nxt = ST_SEND;
            // abort takes priority over a simultaneous final strobe; both leave SEND
            ST_SEND: if (abort || (en && w_last_bit)) w_state_nxt = ST_AFTER;
            ST_GAP:  if (!abort && en && w_gap_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (r_state == ST_IDLE);
        busy     = (r_state == ST_SEND) || (r_state == ST_GAP);
        dout     = (r_state == ST_SEND) && r_sreg[FRAME_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // en is ignored here: the first shift needs a later strobe
                    if (tx_valid) begin
                        r_sreg    <= w_frame;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        r_sreg    <= '0;
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
                    end else if (en) begin
                        r_sreg <= {r_sreg[FRAME_W-2:0], 1'b0};
                        if (w_last_bit) begin
                            r_bit_cnt    <= '0;
                            r_gap_cnt    <= '0;
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 8'd1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_gap_cnt <= '0;
                    end else if (en) begin
                        r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_sreg <= '0;
                end
            endcase
        end
    end

    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
